// File: rtl/jpeg_tx_buffer.sv
// jpeg_tx_buffer: elastic byte FIFO from the JPEG core to the UART transmitter.
// Define JPEG_TX_BUFFER_STUFF_EN to send an extra 0x00 after every transmitted 0xFF.
module jpeg_tx_buffer #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_nrst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_full,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          overflow,
    input  logic          overflow_clr
);
    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, GAP
`ifdef JPEG_TX_BUFFER_STUFF_EN
        , STUFF
`endif
    } state_t;
    state_t state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [7:0] ram_q, data_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic rd_en, push;
    // level never exceeds DEPTH, a power of two, so its top bit alone means full
    assign empty = ~|level;
    assign push = in_valid && (!level[AW] || rd_en);
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= in_data;
        if (rd_en) ram_q <= mem[rd_ptr];
    end
    always_ff @(posedge sys_clk or negedge sys_nrst)
        if (!sys_nrst) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge sys_clk or negedge sys_nrst)
        if (!sys_nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (push != rd_en) level <= push ? level + 1'b1 : level - 1'b1;
            if (state == FETCH) data_q <= ram_q;
            if (in_valid && !push) overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = (!empty && !out_full) ? FETCH : IDLE;
            FETCH: state_nxt = ISSUE;
`ifdef JPEG_TX_BUFFER_STUFF_EN
            ISSUE: state_nxt = (data_q == 8'hFF) ? STUFF : GAP;
            STUFF: state_nxt = out_full ? STUFF : GAP;
`else
            ISSUE: state_nxt = GAP;
`endif
            GAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        rd_en     = (state == IDLE) && !empty && !out_full;
        out_valid = (state == ISSUE);
        out_data  = data_q;
`ifdef JPEG_TX_BUFFER_STUFF_EN
        if (state == STUFF) begin
            out_valid = !out_full;
            out_data  = 8'h00;
        end
`endif
    end
endmodule
